// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: XLEN, the NOP used for flushed/empty slots, and the fetch buffer entry.
// Imported by the fetch stage, its buffer and the interface.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage boundary: hazard/redirect inputs, instruction-memory req/gnt/rvalid port, IF/ID outputs.
// Optional perf counters exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if;
  import rv32i_pkg::*;

  logic            StallF;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            ValidF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_dropped;
`endif

  modport master (
    input  StallF, PCSrcE, PCTargetE, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, InstrF, PCF, PCPlus4F, ValidF
`ifdef FETCH_PERF_CNT_EN
    , output perf_fetched, perf_dropped
`endif
  );

  modport slave (
    output StallF, PCSrcE, PCTargetE, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, InstrF, PCF, PCPlus4F, ValidF
`ifdef FETCH_PERF_CNT_EN
    , input perf_fetched, perf_dropped
`endif
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries; head is visible combinationally, push/pop take effect at the edge.
// Flush empties it in one cycle; push into a full buffer is accepted only together with a pop.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: in-order imem requests, prefetch buffer, redirect flush with in-flight response dropping.
// Word presented the cycle after rvalid; issue throttled by outstanding+buffered <= FIFO_DEPTH; FETCH_PERF_CNT_EN adds counters.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [XLEN-1:0] pc_req;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            pop;
  logic            push;
  logic            dropping;
  logic            grant;
  logic            credit_ok;
  logic [OW-1:0]   occupancy;

  assign redirect = bus.PCSrcE;
  assign target   = word_align(bus.PCTargetE);
  assign pop      = !fifo_empty && !bus.StallF && !redirect;
  assign dropping = bus.imem_rvalid && (drop_cnt != '0);
  assign push     = bus.imem_rvalid && !dropping && !redirect;

  // The word leaving the buffer this cycle frees its slot, which is what sustains 1 instr/cycle.
  assign occupancy = OW'(outstanding) + OW'(fifo_count);
  assign credit_ok = (occupancy - OW'(pop)) < OW'(FIFO_DEPTH);

  assign bus.imem_req  = rst && credit_ok && !redirect;
  assign bus.imem_addr = pc_req;
  assign grant         = bus.imem_req && bus.imem_gnt;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = resp_pc;
    push_entry.instr = bus.imem_rdata;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_req      <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      // No grant can happen here, so whatever is still in flight after this cycle's rvalid is stale.
      pc_req      <= target;
      resp_pc     <= target;
      outstanding <= outstanding - CW'(bus.imem_rvalid);
      drop_cnt    <= outstanding - CW'(bus.imem_rvalid);
    end else begin
      if (grant)    pc_req   <= pc_req + XLEN'(4);
      if (push)     resp_pc  <= resp_pc + XLEN'(4);
      if (dropping) drop_cnt <= drop_cnt - CW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(bus.imem_rvalid);
    end
  end

  always_comb begin
    bus.ValidF   = 1'b0;
    bus.InstrF   = NOP_INSTR;
    bus.PCF      = '0;
    bus.PCPlus4F = '0;
    if (!fifo_empty) begin
      bus.ValidF   = 1'b1;
      bus.InstrF   = head.instr;
      bus.PCF      = head.pc;
      bus.PCPlus4F = head.pc + XLEN'(4);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect)
        perf_dropped_q <= perf_dropped_q + 32'(fifo_count) + 32'(bus.imem_rvalid);
      else if (dropping)
        perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_dropped = perf_dropped_q;
`endif

  a_no_rvalid_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_rvalid && (outstanding == '0)));
  a_drop_within_outstanding: assert property (@(posedge clk) disable iff (!rst)
    drop_cnt <= outstanding);
  a_no_push_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with an in-order variable-latency memory responder.
// Responses carry ~addr as instruction data so every presented InstrF is checkable against its PCF.
module tb_fetch_stage;
  import rv32i_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   mem_lat  = 1;
  int   mcyc     = 0;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  // In-order responder: a grant at edge n is returned as rvalid in the cycle after edge n+mem_lat-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      if (bus.imem_req && bus.imem_gnt) mq.push_back('{bus.imem_addr, mcyc + mem_lat - 1});
      if (mq.size() > 0 && mq[0].due <= mcyc) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= ~mq[0].addr;
        mq.delete(0);
      end else begin
        bus.imem_rvalid <= 1'b0;
      end
      mcyc++;
    end
  end

  typedef struct packed {
    logic        stall;
    logic        gnt;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcf;
  } vec_t;

  vec_t v[42];

  function automatic vec_t mk(logic s, logic g, logic p, logic [31:0] t,
                              logic rq, logic [31:0] a, logic vl, logic [31:0] pc);
    vec_t r;
    r.stall = s; r.gnt = g; r.pcsrc = p; r.tgt = t;
    r.req = rq; r.addr = a; r.valid = vl; r.pcf = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},    32'(bus.imem_req), 32'd0);
    chk({tag, "_addr"},   bus.imem_addr,     32'h0);
    chk({tag, "_valid"},  32'(bus.ValidF),   32'd0);
    chk({tag, "_instr"},  bus.InstrF,        32'h0000_0033);
    chk({tag, "_pcf"},    bus.PCF,           32'h0);
    chk({tag, "_pcplus4"}, bus.PCPlus4F,     32'h0);
  endtask

  // Drives the row's inputs (called just after a rising edge) and checks outputs at the falling edge.
  task automatic apply_row(input int i);
    logic [31:0] exp_instr;
    logic [31:0] exp_p4;
    bus.StallF    = v[i].stall;
    bus.imem_gnt  = v[i].gnt;
    bus.PCSrcE    = v[i].pcsrc;
    bus.PCTargetE = v[i].tgt;
    @(negedge clk);
    exp_instr = v[i].valid ? ~v[i].pcf : 32'h0000_0033;
    exp_p4    = v[i].valid ? v[i].pcf + 32'd4 : 32'h0;
    chk($sformatf("row%0d_req", i),     32'(bus.imem_req), 32'(v[i].req));
    chk($sformatf("row%0d_addr", i),    bus.imem_addr,     v[i].addr);
    chk($sformatf("row%0d_valid", i),   32'(bus.ValidF),   32'(v[i].valid));
    chk($sformatf("row%0d_pcf", i),     bus.PCF,           v[i].pcf);
    chk($sformatf("row%0d_instr", i),   bus.InstrF,        exp_instr);
    chk($sformatf("row%0d_pcplus4", i), bus.PCPlus4F,      exp_p4);
  endtask

  initial begin
    // 1-cycle memory: streaming, 3-cycle stall, 4 cycles without grant, redirects under stall.
    v[0]  = mk(0,1,0,0,       1,32'h000,0,32'h000);
    v[1]  = mk(0,1,0,0,       1,32'h004,0,32'h000);
    v[2]  = mk(0,1,0,0,       1,32'h008,1,32'h000);
    v[3]  = mk(0,1,0,0,       1,32'h00C,1,32'h004);
    v[4]  = mk(1,1,0,0,       0,32'h010,1,32'h008);
    v[5]  = mk(1,1,0,0,       0,32'h010,1,32'h008);
    v[6]  = mk(1,1,0,0,       0,32'h010,1,32'h008);
    v[7]  = mk(0,1,0,0,       1,32'h010,1,32'h008);
    v[8]  = mk(0,1,0,0,       1,32'h014,1,32'h00C);
    v[9]  = mk(0,1,0,0,       1,32'h018,1,32'h010);
    v[10] = mk(0,0,0,0,       1,32'h01C,1,32'h014);
    v[11] = mk(0,0,0,0,       1,32'h01C,1,32'h018);
    v[12] = mk(0,0,0,0,       1,32'h01C,0,32'h000);
    v[13] = mk(0,0,0,0,       1,32'h01C,0,32'h000);
    v[14] = mk(0,1,0,0,       1,32'h01C,0,32'h000);
    v[15] = mk(0,1,0,0,       1,32'h020,0,32'h000);
    v[16] = mk(0,1,0,0,       1,32'h024,1,32'h01C);
    v[17] = mk(0,1,0,0,       1,32'h028,1,32'h020);
    v[18] = mk(1,1,0,0,       0,32'h02C,1,32'h024);
    v[19] = mk(1,1,1,32'h200, 0,32'h02C,1,32'h024);
    v[20] = mk(0,1,0,0,       1,32'h200,0,32'h000);
    v[21] = mk(0,1,0,0,       1,32'h204,0,32'h000);
    v[22] = mk(1,1,1,32'h300, 0,32'h208,1,32'h200);
    v[23] = mk(0,1,0,0,       1,32'h300,0,32'h000);
    v[24] = mk(0,1,0,0,       1,32'h304,0,32'h000);
    v[25] = mk(0,1,0,0,       1,32'h308,1,32'h300);
    // 3-cycle memory: build two in flight, then async reset.
    v[26] = mk(0,1,0,0,       1,32'h000,0,32'h000);
    v[27] = mk(0,1,0,0,       1,32'h004,0,32'h000);
    v[28] = mk(0,1,0,0,       0,32'h008,0,32'h000);
    // 3-cycle memory: restart, then redirect to 0x103 with two responses in flight.
    v[29] = mk(0,1,0,0,       1,32'h000,0,32'h000);
    v[30] = mk(0,1,0,0,       1,32'h004,0,32'h000);
    v[31] = mk(0,1,0,0,       0,32'h008,0,32'h000);
    v[32] = mk(0,1,0,0,       0,32'h008,0,32'h000);
    v[33] = mk(0,1,0,0,       1,32'h008,1,32'h000);
    v[34] = mk(0,1,0,0,       1,32'h00C,1,32'h004);
    v[35] = mk(0,1,1,32'h103, 0,32'h010,0,32'h000);
    v[36] = mk(0,1,0,0,       0,32'h100,0,32'h000);
    v[37] = mk(0,1,0,0,       1,32'h100,0,32'h000);
    v[38] = mk(0,1,0,0,       1,32'h104,0,32'h000);
    v[39] = mk(0,1,0,0,       0,32'h108,0,32'h000);
    v[40] = mk(0,1,0,0,       0,32'h108,0,32'h000);
    v[41] = mk(0,1,0,0,       1,32'h108,1,32'h100);

    rst           = 1'b0;
    bus.StallF    = 1'b0;
    bus.PCSrcE    = 1'b0;
    bus.PCTargetE = '0;
    bus.imem_gnt  = 1'b1;
    mem_lat       = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    chk("reset_outstanding", 32'(dut.outstanding), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i <= 25; i++) begin
      apply_row(i);
      @(posedge clk); #1;
    end

    rst     = 1'b0;
    mem_lat = 3;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 26; i <= 28; i++) begin
      apply_row(i);
      if (i != 28) begin
        @(posedge clk); #1;
      end
    end
    chk("pre_async_outstanding", 32'(dut.outstanding), 32'd2);
    #1 rst = 1'b0;
    #1 chk_reset("async_rst");
    chk("async_rst_outstanding", 32'(dut.outstanding), 32'd0);
    chk("async_rst_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 29; i <= 41; i++) begin
      apply_row(i);
      if (i == 36) chk("redirect_drop_cnt", 32'(dut.drop_cnt), 32'd2);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drop_cnt_back_to_zero", 32'(dut.drop_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
